present_key_schedule: RTL and testbench
=======================================

PRESENT_KEY_SCHEDULE -- requirements
Module: present_key_schedule

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 80, master key width (PRESENT-80).
REQ-002 SHALL have parameter BLOCK_SIZE, default 64, round-key width consumed by the encrypt datapath.
REQ-003 SHALL have parameter NUM_ROUNDS, default 31, cipher rounds; NUM_ROUNDS+1 round keys are emitted.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port key, input, KEY_SIZE, master key; sampled on load handshake.
REQ-007 SHALL have port key_valid, input, 1, master key present.
REQ-008 SHALL have port key_ready, output, 1, block can accept a new key.
REQ-009 SHALL have port rk, output, BLOCK_SIZE, current round key.
REQ-010 SHALL have port rk_idx, output, 6, round-key index, 1..NUM_ROUNDS+1.
REQ-011 SHALL have port rk_valid, output, 1, rk/rk_idx/rk_last valid.
REQ-012 SHALL have port rk_ready, input, 1, downstream encrypt stage accepts rk.
REQ-013 SHALL have port rk_last, output, 1, high with rk_idx == NUM_ROUNDS+1 (final whitening key).

Function
REQ-014 SHALL implement a two-state FSM: IDLE, EMIT.
REQ-015 IDLE: key_ready=1, rk_valid=0; on key_valid&&key_ready, load key into 80-bit key register, set counter=1, go to EMIT next cycle.
REQ-016 EMIT: key_ready=0, rk_valid=1, rk = keyreg[79:16], rk_idx = counter, rk_last = (counter == NUM_ROUNDS+1).
REQ-017 Load-to-first-rk latency SHALL be exactly one cycle; each accepted rk SHALL advance in one cycle, so one rk per cycle under continuous rk_ready.
REQ-018 On rk_valid&&rk_ready with counter < NUM_ROUNDS+1: keyreg <= update(keyreg, counter); counter <= counter+1.
REQ-019 update SHALL be: rotate left by 61; bits[79:76] <= SBOX(bits[79:76]); bits[19:15] ^= counter[4:0]; all in one cycle.
REQ-020 On rk_valid&&rk_ready with rk_last=1: return to IDLE next cycle (rk_valid=0, key_ready=1); no wrap of counter beyond NUM_ROUNDS+1.
REQ-021 Backpressure: while rk_valid&&!rk_ready, rk, rk_idx, rk_last and internal state SHALL hold stable.
REQ-022 key_valid in EMIT SHALL be ignored; the key port SHALL not be sampled outside the IDLE handshake.
REQ-023 In IDLE the key may be loaded in the same cycle the previous schedule finished (back-to-back keys: one idle cycle between last rk and next first rk).

Reset
REQ-024 When rst_n=0 at a clk edge: state=IDLE, counter=0, keyreg=0, so rk_valid=0, key_ready=1, rk=0, rk_idx=0, rk_last=0.
REQ-025 Reset mid-EMIT SHALL abort the schedule; no further rk until a new key is loaded.

Structure
REQ-026 Package present_pkg SHALL hold KEY_SIZE, BLOCK_SIZE, NUM_ROUNDS and the 16-entry 4-bit SBOX constant (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2), shared with the encrypt datapath.
REQ-027 One sub-module present_sbox (4-bit in, 4-bit out, combinational) SHALL be instantiated for the key-register nibble; the encrypt substitution layer reuses it.

Verification
REQ-028 key=80'h0, rk_ready=1 -> rk_idx 1,2,3 give rk 0000000000000000, C000000000000000, 5000180000000001 on consecutive cycles.
REQ-029 key=80'h0, rk_ready=1 -> exactly 32 rk beats, rk_last only on rk_idx=32, key_ready back high the following cycle.
REQ-030 rk_ready deasserted 3 cycles at rk_idx=5 -> rk/rk_idx stable for those cycles; sequence identical to REQ-028 run.
REQ-031 rst_n=0 while rk_idx=10 -> next cycle rk_valid=0, key_ready=1; reload key=80'hFFFF_FFFF_FFFF_FFFF_FFFF -> rk_idx=1 rk=FFFFFFFFFFFFFFFF.
REQ-032 key_valid pulsed with a different key during EMIT -> ignored; schedule unchanged vs. reference model.
REQ-033 Integrated with the encrypt stage, key=0, plaintext=0 -> ciphertext 64'h5579C1387B228445.

Source files
------------

// File: rtl/present_pkg.sv
// ============================================================================
// Module      : present_pkg
// Description : Shared PRESENT-80 constants and the 4-bit substitution table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package present_pkg;

    localparam int KEY_SIZE   = 80;
    localparam int BLOCK_SIZE = 64;
    localparam int NUM_ROUNDS = 31;

    // Nibble n of the word holds SBOX(n): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_t;

endpackage

`default_nettype wire

// File: rtl/present_sbox.sv
// ============================================================================
// Module      : present_sbox
// Description : Combinational 4-bit PRESENT substitution box.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    logic [5:0] w_base;

    assign w_base   = {nibble_i, 2'b00};
    assign nibble_o = SBOX[w_base +: 4];

endmodule

`default_nettype wire

// File: rtl/present_key_schedule.sv
// ============================================================================
// Module      : present_key_schedule
// Description : PRESENT-80 round-key generator, one round key per accepted beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_key_schedule
    import present_pkg::*;
#(
    parameter int KEY_SIZE   = present_pkg::KEY_SIZE,
    parameter int BLOCK_SIZE = present_pkg::BLOCK_SIZE,
    parameter int NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic                  key_valid,
    output logic                  key_ready,
    output logic [BLOCK_SIZE-1:0] rk,
    output logic [5:0]            rk_idx,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic                  rk_last
);

    localparam logic [5:0] c_LAST_IDX = 6'(NUM_ROUNDS + 1);

    ks_state_t             state_q, state_d;
    logic [KEY_SIZE-1:0]   keyreg_q, keyreg_d;
    logic [5:0]            counter_q, counter_d;

    logic [KEY_SIZE-1:0]   w_rot_key;
    logic [KEY_SIZE-1:0]   w_next_key;
    logic [3:0]            w_sbox_out;

    // Rotate left by 61 is the same as rotate right by 19.
    assign w_rot_key = {keyreg_q[18:0], keyreg_q[KEY_SIZE-1:19]};

    present_sbox u_sbox (
        .nibble_i (w_rot_key[KEY_SIZE-1 -: 4]),
        .nibble_o (w_sbox_out)
    );

    always_comb begin
        w_next_key                   = w_rot_key;
        w_next_key[KEY_SIZE-1 -: 4]  = w_sbox_out;
        w_next_key[19:15]            = w_rot_key[19:15] ^ counter_q[4:0];
    end

    always_comb begin
        state_d   = state_q;
        keyreg_d  = keyreg_q;
        counter_d = counter_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    keyreg_d  = key;
                    counter_d = 6'd1;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (counter_q == c_LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        keyreg_d  = w_next_key;
                        counter_d = counter_q + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            keyreg_q  <= '0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            keyreg_q  <= keyreg_d;
            counter_q <= counter_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign rk_valid  = (state_q == ST_EMIT);
    assign rk        = keyreg_q[KEY_SIZE-1 -: BLOCK_SIZE];
    assign rk_idx    = counter_q;
    assign rk_last   = rk_valid && (counter_q == c_LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_present_key_schedule.sv
// ============================================================================
// Module      : tb_present_key_schedule
// Description : Self-checking bench for present_key_schedule against a key model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_present_key_schedule;

    localparam int NR   = 31;
    localparam int LAST = NR + 1;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [79:0] key       = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] rk;
    logic [5:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready  = 1'b0;
    logic        rk_last;

    always #5 clk = ~clk;

    present_key_schedule #(
        .KEY_SIZE   (80),
        .BLOCK_SIZE (64),
        .NUM_ROUNDS (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [63:0] exp_rk [1:32];
    logic [63:0] obs_rk [1:32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference schedule computed directly from the cipher's key-update rule.
    task automatic model_keys(input logic [79:0] k_in);
        logic [79:0] k;
        k = k_in;
        for (int i = 1; i <= LAST; i++) begin
            exp_rk[i] = k[79:16];
            k = (k << 61) | (k >> 19);
            k[79:76] = sb[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(i);
        end
    endtask

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] s;
        logic [63:0] p;
        s = pt;
        for (int r = 1; r <= NR; r++) begin
            s = s ^ obs_rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
            p = '0;
            for (int i = 0; i < 63; i++) p[(16*i) % 63] = s[i];
            p[63] = s[63];
            s = p;
        end
        return s ^ obs_rk[LAST];
    endfunction

    // Called at a falling edge with the DUT idle; leaves at a falling edge.
    task automatic run_schedule(input logic [79:0] k, input int mode, input int stall_at,
                                input int stall_len, input bit intrude, input int stop_at);
        int idx;
        int stall_cnt;
        int guard;
        idx = 1;
        stall_cnt = 0;
        guard = 0;
        model_keys(k);
        chk("key_ready_idle", 64'(key_ready), 64'd1);
        key       = k;
        key_valid = 1'b1;
        rk_ready  = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        while (idx <= LAST && guard < 500) begin
            guard++;
            chk("rk_valid", 64'(rk_valid), 64'd1);
            chk("key_ready_emit", 64'(key_ready), 64'd0);
            chk("rk_idx", 64'(rk_idx), 64'(idx));
            chk("rk", rk, exp_rk[idx]);
            chk("rk_last", 64'(rk_last), 64'(idx == LAST));
            if (stop_at == idx) begin
                rk_ready = 1'b0;
                return;
            end
            if (idx == stall_at && stall_cnt < stall_len) begin
                rk_ready = 1'b0;
                stall_cnt++;
            end else if (mode == 1) begin
                rk_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rk_ready = 1'b1;
            end
            if (intrude) begin
                key       = {16'($urandom), $urandom, $urandom};
                key_valid = 1'($urandom_range(0, 1));
            end
            if (rk_ready) begin
                obs_rk[idx] = rk;
                idx++;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        chk("schedule_completed", 64'(idx > LAST), 64'd1);
        chk("done_rk_valid", 64'(rk_valid), 64'd0);
        chk("done_key_ready", 64'(key_ready), 64'd1);
        chk("done_rk_last", 64'(rk_last), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rk_valid", 64'(rk_valid), 64'd0);
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_rk", rk, 64'd0);
        chk("rst_rk_idx", 64'(rk_idx), 64'd0);
        chk("rst_rk_last", 64'(rk_last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero key, continuous acceptance: known vectors and ciphertext.
        run_schedule(80'h0, 0, 0, 0, 1'b0, 0);
        chk("zero_rk1", obs_rk[1], 64'h0000000000000000);
        chk("zero_rk2", obs_rk[2], 64'hC000000000000000);
        chk("zero_rk3", obs_rk[3], 64'h5000180000000001);
        chk("cipher_zero", encrypt(64'h0), 64'h5579C1387B228445);

        // Back-to-back reload with a 3-cycle stall at index 5.
        run_schedule(80'h0, 0, 5, 3, 1'b0, 0);

        // Random keys, random backpressure, stray key_valid during emission.
        for (int t = 0; t < 3; t++) begin
            run_schedule({16'($urandom), $urandom, $urandom}, 1, 0, 0, 1'b1, 0);
        end

        // Reset while index 10 is presented.
        run_schedule({16'($urandom), $urandom, $urandom}, 0, 0, 0, 1'b0, 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_rk_valid", 64'(rk_valid), 64'd0);
        chk("midrst_key_ready", 64'(key_ready), 64'd1);
        chk("midrst_rk_idx", 64'(rk_idx), 64'd0);
        chk("midrst_rk", rk, 64'd0);
        @(negedge clk);
        chk("post_rst_idle", 64'(rk_valid), 64'd0);
        run_schedule(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1'b0, 0);
        chk("ones_rk1", obs_rk[1], 64'hFFFFFFFFFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
